// File: rtl/scan_multiplexer.sv
// scan_multiplexer: registered N-channel mux with manual select and round-robin scan at a programmable dwell
module scan_multiplexer #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL_W  = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      Clock,
  input  logic                      nReset,
  input  logic [CHANNELS*WIDTH-1:0] DataIn,
  input  logic [SEL_W-1:0]          Selector,
  input  logic                      Mode,
  input  logic [DWELL_W-1:0]        Dwell,
  input  logic                      Hold,
  output logic [WIDTH-1:0]          DataOut,
  output logic [SEL_W-1:0]          ChannelOut,
  output logic                      Strobe
);
  typedef enum logic {MANUAL, SCAN} state_t;
  state_t state, state_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt, last;
  logic [SEL_W-1:0] chan_nxt;
  logic [WIDTH-1:0] slice [2**SEL_W];
  logic tc;
  // indices past CHANNELS-1 read as zero so an out-of-range selector yields DataOut=0
  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_slice
    if (i < CHANNELS) begin : g_in
      assign slice[i] = DataIn[i*WIDTH +: WIDTH];
    end else begin : g_oor
      assign slice[i] = '0;
    end
  end
  always_comb begin
    state_nxt = Mode ? SCAN : MANUAL;
    last = (Dwell == '0) ? '0 : Dwell - DWELL_W'(1);
    tc = cnt >= last;
    chan_nxt = ChannelOut;
    cnt_nxt = cnt;
    if (state == MANUAL) begin
      chan_nxt = Selector;
      cnt_nxt = '0;
    end else if (!Hold) begin
      cnt_nxt = tc ? '0 : cnt + DWELL_W'(1);
      if (tc) chan_nxt = (ChannelOut >= SEL_W'(CHANNELS-1)) ? '0 : ChannelOut + SEL_W'(1);
    end
  end
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= MANUAL;
      cnt <= '0;
      ChannelOut <= '0;
      DataOut <= '0;
      Strobe <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      ChannelOut <= chan_nxt;
      DataOut <= slice[chan_nxt];
      Strobe <= chan_nxt != ChannelOut;
    end
  end
endmodule

// File: tb/tb_scan_multiplexer.sv
// tb_scan_multiplexer: directed and random checks of scan_multiplexer against a cycle-level reference model
module tb_scan_multiplexer;
  localparam int W = 4, N = 4, DW = 16;
  logic Clock = 1'b0, nReset = 1'b0;
  logic [N*W-1:0] DataIn;
  logic [1:0] Selector;
  logic Mode, Hold;
  logic [DW-1:0] Dwell;
  logic [W-1:0] DataOut;
  logic [1:0] ChannelOut;
  logic Strobe;
  logic [3*W-1:0] din3;
  logic [1:0] sel3;
  logic mode3;
  logic [DW-1:0] dwell3;
  logic [W-1:0] dout3;
  logic [1:0] ch3;
  logic stb3;
  int compared = 0, mismatched = 0;
  int m_ch = 0, m_prev = 0, m_age = 0;
  bit m_scan = 0;
  int rot[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  scan_multiplexer #(.WIDTH(W), .CHANNELS(N), .DWELL_W(DW)) dut (
    .Clock(Clock), .nReset(nReset), .DataIn(DataIn), .Selector(Selector), .Mode(Mode),
    .Dwell(Dwell), .Hold(Hold), .DataOut(DataOut), .ChannelOut(ChannelOut), .Strobe(Strobe));

  scan_multiplexer #(.WIDTH(W), .CHANNELS(3), .DWELL_W(DW)) dut3 (
    .Clock(Clock), .nReset(nReset), .DataIn(din3), .Selector(sel3), .Mode(mode3),
    .Dwell(dwell3), .Hold(1'b0), .DataOut(dout3), .ChannelOut(ch3), .Strobe(stb3));

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each channel is shown for max(Dwell,1) cycles; manual follows Selector; Mode seen one edge late
  task automatic model_edge();
    int d;
    m_prev = m_ch;
    if (!m_scan) begin
      m_ch = int'(Selector);
      m_age = 0;
    end else if (!Hold) begin
      d = (Dwell == 0) ? 1 : int'(Dwell);
      m_age++;
      if (m_age >= d) begin
        m_age = 0;
        m_ch = (m_ch + 1) % N;
      end
    end
    m_scan = Mode;
  endtask

  task automatic step(input string tag);
    @(posedge Clock);
    model_edge();
    #1;
    chk({tag, " ch"}, ChannelOut, m_ch);
    chk({tag, " data"}, DataOut, DataIn[m_ch*W +: W]);
    chk({tag, " strobe"}, Strobe, m_ch != m_prev);
  endtask

  initial begin
    DataIn = 16'hDCBA; Selector = 0; Mode = 0; Hold = 0; Dwell = 3;
    din3 = 12'hCBA; sel3 = 3; mode3 = 0; dwell3 = 2;
    #12;
    chk("reset data", DataOut, 0);
    chk("reset ch", ChannelOut, 0);
    chk("reset strobe", Strobe, 0);
    nReset = 1;
    step("rst_release");
    chk("ch3 oor ch", ch3, 3);
    chk("ch3 oor data", dout3, 0);
    mode3 = 1;
    for (int i = 0; i < 4; i++) begin
      Selector = 2'(i);
      step("manual");
      chk("manual const data", DataOut, 4'hA + i);
      if (i == 1) chk("ch3 scan entry", ch3, 3);
      if (i == 2) begin
        chk("ch3 wrap ch", ch3, 0);
        chk("ch3 wrap data", dout3, 4'hA);
        chk("ch3 wrap strobe", stb3, 1);
      end
    end
    Selector = 0; Mode = 1; Dwell = 3;
    for (int j = 0; j < 13; j++) begin
      step("scan");
      chk("scan rot const", ChannelOut, rot[j]);
    end
    Dwell = 0;
    for (int j = 0; j < 5; j++) step("dwell0");
    Dwell = 3;
    for (int k = 0; k < 20 && m_ch != 2; k++) step("to_ch2");
    chk("reached ch2", ChannelOut, 2);
    Hold = 1;
    for (int j = 0; j < 5; j++) begin
      if (j == 2) DataIn[11:8] = 4'h7;
      step("hold");
      chk("hold ch const", ChannelOut, 2);
    end
    chk("hold new data", DataOut, 7);
    Hold = 0;
    for (int j = 0; j < 6; j++) step("unhold");
    for (int k = 0; k < 20 && m_ch != 3; k++) step("to_ch3");
    Selector = 1; Mode = 0;
    step("to_manual");
    step("to_manual");
    chk("mode switch ch", ChannelOut, 1);
    Mode = 1;
    for (int j = 0; j < 8; j++) step("rescan");
    @(posedge Clock);
    model_edge();
    #3 nReset = 0;
    #1;
    chk("async data", DataOut, 0);
    chk("async ch", ChannelOut, 0);
    chk("async strobe", Strobe, 0);
    m_ch = 0; m_prev = 0; m_age = 0; m_scan = 0;
    Selector = 0; Mode = 0;
    @(negedge Clock);
    #2 nReset = 1;
    step("post_reset");
    for (int j = 0; j < 300; j++) begin
      DataIn = 16'($urandom);
      Selector = 2'($urandom);
      if ($urandom_range(0, 9) == 0) Mode = ~Mode;
      Hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) Dwell = 16'($urandom_range(0, 4));
      step("random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/scan_multiplexer.md
# scan_multiplexer

Parametrised, registered N-channel multiplexer. Supports manual channel selection and an automatic round-robin scan mode with a programmable dwell time per channel. The block sits between per-channel data sources (switch banks, BCD digits, counters) and a single shared consumer such as a Basys3 seven-segment digit driver. It reports which channel is on the output and pulses a strobe whenever that channel changes.

## Interface
Parameters:
- WIDTH, 4, bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- DWELL_W, 16, width of the dwell-count input and internal dwell counter.
- SEL_W, $clog2(CHANNELS), width of channel indices (derived; do not override).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- DataIn  in  CHANNELS*WIDTH  packed inputs; channel k occupies DataIn[k*WIDTH +: WIDTH].
- Selector  in  SEL_W  channel index used in manual mode.
- Mode  in  1  0 = manual, 1 = scan.
- Dwell  in  DWELL_W  cycles spent on each channel in scan mode; 0 is treated as 1.
- Hold  in  1  in scan mode, freezes channel and dwell counter.
- DataOut  out  WIDTH  registered data of the current channel.
- ChannelOut  out  SEL_W  registered index of the channel on DataOut.
- Strobe  out  1  one-cycle pulse on the cycle ChannelOut takes a new value.

## Operation
- Reset (nReset=0) acts immediately and asynchronously:
  - DataOut=0, ChannelOut=0, Strobe=0.
  - Dwell counter=0, state=MANUAL.
- State register follows Mode with one cycle of latency. States: MANUAL, SCAN.
- **MANUAL:**
  - Next channel = Selector.
  - DataOut <= DataIn slice of that channel.
- **SCAN:**
  - Dwell counter counts 0..max(Dwell,1)-1.
  - At terminal count, the counter clears and the channel advances by 1.
  - CHANNELS-1 wraps to 0.
  - Otherwise the channel is unchanged and the counter increments.
- **Hold=1 in SCAN:** counter and channel are frozen. DataOut still tracks DataIn of the current channel every cycle. Hold is ignored in MANUAL.
- **MANUAL→SCAN:** scan starts from the current ChannelOut with the dwell counter cleared.
- **SCAN→MANUAL:** channel = Selector on the first MANUAL cycle.
- **Dwell changed mid-count:** the new value takes effect immediately. If counter >= new max(Dwell,1)-1, the channel advances on the next edge.
- **Selector >= CHANNELS** (only possible when CHANNELS is not a power of two):
  - ChannelOut = Selector and DataOut = 0.
  - In SCAN, an out-of-range channel at entry wraps to 0 on the next advance.
- **Strobe:** 1 exactly in cycles where ChannelOut differs from its value in the previous cycle.
  - No Strobe on the first cycle after reset release.
  - No Strobe while ChannelOut is stable, even if DataOut changes.
- DataOut and ChannelOut always refer to the same channel in the same cycle.

## Timing
- Latency from DataIn or Selector change to DataOut/ChannelOut: 1 clock edge.
- Scan with Dwell=D: every channel is presented for exactly max(D,1) consecutive cycles; full rotation = CHANNELS*max(D,1) cycles.
- Strobe is coincident with the first cycle of the new ChannelOut value.
- Mode takes effect one edge after it changes: the state register updates, then the next edge applies the new selection rule.
- Reset release: first functional update on the first rising edge with nReset=1.
- Dwell counter is DWELL_W bits wide and never overflows, since terminal count is at most 2^DWELL_W-2.

## Test plan
All scenarios use CHANNELS=4, WIDTH=4, DataIn={4'hD,4'hC,4'hB,4'hA}.
1. **Manual sweep:** Mode=0, Selector 0→1→2→3, one step per cycle → DataOut A,B,C,D one cycle after each step; ChannelOut 0..3; Strobe=1 on each change.
2. **Scan rotation:** Mode=1, Dwell=3 → ChannelOut 0,0,0,1,1,1,2,2,2,3,3,3,0; Strobe on the first cycle of each channel including the 3→0 wrap; Dwell=0 → channel changes every cycle.
3. **Hold:** Hold=1 for 5 cycles while on channel 2; change DataIn[11:8] to 4'h7 during Hold → ChannelOut stays 2, DataOut=7 one cycle later; after release, the remaining dwell cycles complete, then channel 3.
4. **Mode switch:** scanning on channel 3, Mode→0 with Selector=1 → ChannelOut=1 and Strobe=1 within 2 edges; back to Mode=1 → scan resumes from channel 1 with a full dwell.
5. **Asynchronous reset mid-scan:** pull nReset low between clock edges → DataOut=0 and ChannelOut=0 immediately; after release, no Strobe on the first edge.
6. **CHANNELS=3 build:** Selector=3 → DataOut=0, ChannelOut=3; switching to scan → next advance goes to channel 0.
